// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-RAM masters, the arbiter and the single-port data RAM.
// Signal names keep the i_/o_ direction as seen from the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  i_req0;
  logic                  i_we0;
  logic [ADDR_WIDTH-1:0] i_addr0;
  logic [DATA_WIDTH-1:0] i_wrdata0;
  logic                  o_gnt0;
  logic                  o_rvalid0;
  logic [DATA_WIDTH-1:0] o_rdata0;

  logic                  i_req1;
  logic                  i_we1;
  logic [ADDR_WIDTH-1:0] i_addr1;
  logic [DATA_WIDTH-1:0] i_wrdata1;
  logic                  i_lock1;
  logic                  o_gnt1;
  logic                  o_rvalid1;
  logic [DATA_WIDTH-1:0] o_rdata1;

  logic                  o_we_mem;
  logic [ADDR_WIDTH-1:0] o_addr_mem;
  logic [DATA_WIDTH-1:0] o_wrdata_mem;
  logic [DATA_WIDTH-1:0] i_rdata_mem;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wrdata0,
    output o_gnt0, o_rvalid0, o_rdata0,
    input  i_req1, i_we1, i_addr1, i_wrdata1, i_lock1,
    output o_gnt1, o_rvalid1, o_rdata1,
    output o_we_mem, o_addr_mem, o_wrdata_mem,
    input  i_rdata_mem
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wrdata0,
    input  o_gnt0, o_rvalid0, o_rdata0,
    output i_req1, i_we1, i_addr1, i_wrdata1, i_lock1,
    input  o_gnt1, o_rvalid1, o_rdata1,
    input  o_we_mem, o_addr_mem, o_wrdata_mem,
    output i_rdata_mem
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: per-cycle round-robin with a bounded
// port-1 burst lock, and registered read-valid routing back to the issuing port.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_LOCK   = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);

  typedef enum logic [0:0] {StIdle, StLock1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            rr_last_q, rr_last_d;  // 1: port 1 won most recently
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic            gnt0, gnt1;

  // Grants are suppressed while reset is asserted, even though reset is asynchronous.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_rst_n) begin
      if (state_q == StLock1) begin
        gnt1 = bus.i_req1;
      end else if (bus.i_req0 && bus.i_req1) begin
        gnt0 = rr_last_q;
        gnt1 = ~rr_last_q;
      end else begin
        gnt0 = bus.i_req0;
        gnt1 = bus.i_req1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    if (gnt0) rr_last_d = 1'b0;
    if (gnt1) rr_last_d = 1'b1;
    case (state_q)
      StIdle: begin
        // With MAX_LOCK == 1 the first grant already exhausts the burst, so never lock.
        if (gnt1 && bus.i_lock1 && (MAX_LOCK > 1)) begin
          state_d    = StLock1;
          lock_cnt_d = CntW'(1);
        end
      end
      StLock1: begin
        if (!gnt1 || !bus.i_lock1 || (lock_cnt_q + CntW'(1) == MaxCnt)) begin
          state_d    = StIdle;
          lock_cnt_d = '0;
          rr_last_d  = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign rvalid0_d = gnt0 & ~bus.i_we0;
  assign rvalid1_d = gnt1 & ~bus.i_we1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      rr_last_q  <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rr_last_q  <= rr_last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  always_comb begin
    bus.o_we_mem     = 1'b0;
    bus.o_addr_mem   = '0;
    bus.o_wrdata_mem = '0;
    if (gnt0) begin
      bus.o_we_mem     = bus.i_we0;
      bus.o_addr_mem   = bus.i_addr0;
      bus.o_wrdata_mem = bus.i_wrdata0;
    end else if (gnt1) begin
      bus.o_we_mem     = bus.i_we1;
      bus.o_addr_mem   = bus.i_addr1;
      bus.o_wrdata_mem = bus.i_wrdata1;
    end
  end

  assign bus.o_gnt0    = gnt0;
  assign bus.o_gnt1    = gnt1;
  assign bus.o_rvalid0 = rvalid0_q;
  assign bus.o_rvalid1 = rvalid1_q;
  assign bus.o_rdata0  = bus.i_rdata_mem;
  assign bus.o_rdata1  = bus.i_rdata_mem;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: a reference model predicts grants and RAM drive each
// cycle, and read responses are queued per port and checked when the DUT returns them.
module tb_dmem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned MAX_LOCK = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(MAX_LOCK)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous RAM with one-cycle read latency; unwritten words read a fixed hash.
  logic [DW-1:0] ram    [1<<AW];
  bit            ram_wr [1<<AW];
  always @(posedge clk) begin
    if (bus.o_we_mem) begin
      ram[bus.o_addr_mem]    <= bus.o_wrdata_mem;
      ram_wr[bus.o_addr_mem] <= 1'b1;
    end
    bus.i_rdata_mem <= ram_wr[bus.o_addr_mem] ? ram[bus.o_addr_mem] : seed(bus.o_addr_mem);
  end

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] shadow [1<<AW];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: who won last, and whether port 1 holds a burst and how long it is.
  bit m_last = 1'b1;
  bit m_locked = 1'b0;
  int m_burst = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin
      chk("rvalid0", bus.o_rvalid0, 1);
      chk("rdata0", bus.o_rdata0, q0[0].data);
      void'(q0.pop_front());
    end else chk("rvalid0_quiet", bus.o_rvalid0, 0);
    if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin
      chk("rvalid1", bus.o_rvalid1, 1);
      chk("rdata1", bus.o_rdata1, q1[0].data);
      void'(q1.pop_front());
    end else chk("rvalid1_quiet", bus.o_rvalid1, 0);
  end

  task automatic set_p0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_req0 = r; bus.i_we0 = w; bus.i_addr0 = a; bus.i_wrdata0 = d;
  endtask

  task automatic set_p1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit l);
    bus.i_req1 = r; bus.i_we1 = w; bus.i_addr1 = a; bus.i_wrdata1 = d; bus.i_lock1 = l;
  endtask

  // Compare the combinational outputs of the current cycle, then advance the model.
  task automatic check_cycle(output bit g0, output bit g1);
    bit e0, e1;
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    @(negedge clk);
    e0 = 1'b0; e1 = 1'b0;
    if (rst_n) begin
      if (m_locked) e1 = bus.i_req1;
      else if (bus.i_req0 && bus.i_req1) begin e0 = m_last; e1 = !m_last; end
      else begin e0 = bus.i_req0; e1 = bus.i_req1; end
    end
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (e0) begin exp_we = bus.i_we0; exp_addr = bus.i_addr0; exp_wd = bus.i_wrdata0; end
    if (e1) begin exp_we = bus.i_we1; exp_addr = bus.i_addr1; exp_wd = bus.i_wrdata1; end
    g0 = bus.o_gnt0;
    g1 = bus.o_gnt1;
    chk("gnt0", g0, e0);
    chk("gnt1", g1, e1);
    chk("we_mem", bus.o_we_mem, exp_we);
    chk("addr_mem", bus.o_addr_mem, exp_addr);
    chk("wrdata_mem", bus.o_wrdata_mem, exp_wd);
    if (e0 && !bus.i_we0) q0.push_back('{shadow[bus.i_addr0], cyc});
    if (e0 && bus.i_we0) shadow[bus.i_addr0] = bus.i_wrdata0;
    if (e1 && !bus.i_we1) q1.push_back('{shadow[bus.i_addr1], cyc});
    if (e1 && bus.i_we1) shadow[bus.i_addr1] = bus.i_wrdata1;
    if (rst_n) begin
      if (m_locked) begin
        if (!bus.i_req1 || !bus.i_lock1) m_locked = 1'b0;
        else begin
          m_burst++;
          if (m_burst >= MAX_LOCK) m_locked = 1'b0;
        end
      end else if (e1 && bus.i_lock1) begin
        m_burst = 1;
        m_locked = (MAX_LOCK > 1);
      end
      if (e0) m_last = 1'b0;
      if (e1) m_last = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(output bit g0, output bit g1);
    check_cycle(g0, g1);
    advance();
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_last = 1'b1; m_locked = 1'b0; m_burst = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a = a | AW'(10'h3F8);
    return a;
  endfunction

  initial begin
    bit g0, g1, p0, p1;
    bit gs0 [12];
    bit gs1 [12];
    int run;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = seed(AW'(i));

    // Reset with both ports requesting.
    set_p0(1, 0, 10'h001, '0);
    set_p1(1, 0, 10'h002, '0, 0);
    for (int i = 0; i < 3; i++) begin
      step(g0, g1);
      chk("reset_no_gnt", {g0, g1}, 2'b00);
    end
    rst_n = 1'b1;
    model_reset();
    step(g0, g1);
    chk("first_tie_port0", g0, 1);
    set_p0(0, 0, '0, '0);
    step(g0, g1);  // port 1 still pending, granted alone
    set_p1(0, 0, '0, '0, 0);

    set_p0(1, 0, 10'h010, '0);
    check_cycle(g0, g1);
    chk("single_read_addr", bus.o_addr_mem, 10'h010);
    advance();
    set_p0(0, 0, '0, '0);
    set_p1(1, 0, 10'h020, '0, 0);
    step(g0, g1);
    set_p1(0, 0, '0, '0, 0);
    step(g0, g1);

    // Continuous tie after a port-1 win: expect 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      set_p0(1, 0, AW'(10'h040 + i), '0);
      set_p1(1, 0, AW'(10'h080 + i), '0, 0);
      step(g0, g1);
      chk("tie_alternate", {g0, g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    set_p0(0, 0, '0, '0);
    set_p1(1, 1, 10'h3FF, 32'hDEAD_BEEF, 0);
    check_cycle(g0, g1);
    chk("write_we_mem", bus.o_we_mem, 1);
    advance();
    set_p1(0, 0, '0, '0, 0);
    set_p0(1, 0, 10'h3FF, '0);
    step(g0, g1);
    set_p0(0, 0, '0, '0);
    step(g0, g1);
    chk("write_readback", shadow[10'h3FF], 32'hDEAD_BEEF);

    // Lock burst against a continuously requesting port 0.
    for (int i = 0; i < 11; i++) begin
      set_p0(1, 0, AW'(10'h100 + i), '0);
      set_p1(1, 0, AW'(10'h200 + i), '0, 1);
      step(g0, g1);
      gs0[i] = g0;
      gs1[i] = g1;
    end
    run = 0;
    while (run < 11 && gs1[run]) run++;
    chk("lock_run_len", run, MAX_LOCK);
    chk("after_lock_gnt0", gs0[8], 1);
    chk("relock_gnt1", {gs1[9], gs1[10]}, 2'b11);

    // Reset in the middle of a lock with a port-1 read in flight.
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    step(g0, g1);
    step(g0, g1);
    for (int i = 0; i < 3; i++) begin
      set_p1(1, 0, AW'(10'h300 + i), '0, 1);
      step(g0, g1);
    end
    set_p0(1, 0, 10'h011, '0);
    check_cycle(g0, g1);
    chk("midlock_gnt1", {g0, g1}, 2'b01);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midlock_rvalid1_dropped", bus.o_rvalid1, 0);
    advance();
    step(g0, g1);
    step(g0, g1);
    rst_n = 1'b1;
    set_p1(1, 0, 10'h012, '0, 0);
    step(g0, g1);
    chk("post_reset_tie_port0", g0, 1);
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    step(g0, g1);

    // Random traffic; a request is held with its payload until granted.
    p0 = 0; p1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0) set_p0($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, rnd_addr(), $urandom);
      if (!p1) set_p1($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, rnd_addr(), $urandom,
                      $urandom_range(0, 4) != 0);
      else bus.i_lock1 = ($urandom_range(0, 7) != 0);
      step(g0, g1);
      p0 = bus.i_req0 && !g0;
      p1 = bus.i_req1 && !g1;
    end
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) step(g0, g1);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
